// File: rtl/sprite_overlay_fetch_pkg.sv
// Shared types and constants for the sprite overlay fetch block: pixel type,
// default sprite geometry, colour key, pipeline latency and FSM encoding.
package sprite_overlay_fetch_pkg;

  typedef logic [15:0] rgb565_t;

  localparam int unsigned SPR_W_DEF   = 90;
  localparam int unsigned SPR_H_DEF   = 90;
  localparam rgb565_t     KEY_COLOR_DEF = 16'hF81F;
  localparam int unsigned LATENCY     = 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_TOP = 2'd1;
  localparam logic [1:0] ST_DRAW     = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  function automatic logic is_opaque(input rgb565_t texel, input rgb565_t key);
    return (texel != key);
  endfunction

endpackage

// File: rtl/sprite_overlay_fetch_delay_line.sv
// Parameterised N-stage register pipe with asynchronous reset, used to keep
// side-band pixel data aligned with the ROM read latency.
module sprite_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sprite_overlay_fetch.sv
// Sprite ROM address generator and colour-keyed overlay; outputs trail the
// pixel inputs by LATENCY cycles so delayed upstream timing stays aligned.
module sprite_overlay_fetch
  import sprite_overlay_fetch_pkg::*;
#(
  parameter int unsigned SPR_W     = SPR_W_DEF,
  parameter int unsigned SPR_H     = SPR_H_DEF,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned COORD_W   = 10,
  parameter rgb565_t     KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               de,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [15:0]        bg_pixel,
  input  logic               spr_en,
  input  logic [COORD_W-1:0] spr_x,
  input  logic [COORD_W-1:0] spr_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [15:0]        rom_data,
  output logic [15:0]        pix_out,
  output logic               pix_de,
  output logic               spr_hit
);

  localparam int unsigned XW = COORD_W + 1;

  logic [1:0]         state_q, state_d;
  logic               en_q;
  logic [COORD_W-1:0] x_q, y_q, prev_y_q;
  logic [ADDR_W-1:0]  row_base_q, row_base_d, row_eff_s;
  logic [ADDR_W-1:0]  addr_q;

  logic [XW-1:0]      x_end_s, y_end_s;
  logic [COORD_W-1:0] col_s;
  logic               y_changed_s, top_hit_s, bottom_s, draw_now_s, inside_s;

  logic               inside_d1, de_d1;
  rgb565_t            bg_d1;
  logic [15:0]        pix_out_q, pix_out_d;
  logic               pix_de_q, spr_hit_q, spr_hit_d;

  // Extents computed one bit wider so x_l+SPR_W cannot wrap.
  assign x_end_s     = {1'b0, x_q} + XW'(SPR_W);
  assign y_end_s     = {1'b0, y_q} + XW'(SPR_H);
  assign y_changed_s = (pix_y != prev_y_q);
  assign top_hit_s   = de && (pix_y == y_q);
  assign bottom_s    = y_changed_s && ({1'b0, pix_y} == y_end_s);
  assign col_s       = pix_x - x_q;

  always_comb begin
    draw_now_s = 1'b0;
    if (frame_start || !en_q) begin
      draw_now_s = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_TOP: draw_now_s = top_hit_s;
        ST_DRAW:     draw_now_s = !bottom_s;
        default:     draw_now_s = 1'b0;
      endcase
    end
  end

  assign inside_s = draw_now_s && de &&
                    ({1'b0, pix_x} >= {1'b0, x_q}) &&
                    ({1'b0, pix_x} < x_end_s);

  // A new row's first pixel already uses the advanced base, so x_l=0 works.
  always_comb begin
    row_eff_s = row_base_q;
    if ((state_q == ST_DRAW) && y_changed_s) begin
      row_eff_s = row_base_q + ADDR_W'(SPR_W);
    end else begin
      row_eff_s = row_base_q;
    end
  end

  assign rom_addr = inside_s ? (row_eff_s + ADDR_W'(col_s)) : addr_q;

  always_comb begin
    state_d    = state_q;
    row_base_d = row_base_q;
    if (frame_start) begin
      state_d    = spr_en ? ST_WAIT_TOP : ST_IDLE;
      row_base_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_WAIT_TOP: begin
          if (top_hit_s) begin
            state_d = ST_DRAW;
          end else begin
            state_d = ST_WAIT_TOP;
          end
        end
        ST_DRAW: begin
          if (bottom_s) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_DRAW;
            row_base_d = row_eff_s;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      prev_y_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
      prev_y_q   <= pix_y;
      addr_q     <= rom_addr;
      if (frame_start) begin
        en_q <= spr_en;
        x_q  <= spr_x;
        y_q  <= spr_y;
      end else begin
        en_q <= en_q;
        x_q  <= x_q;
        y_q  <= y_q;
      end
    end
  end

  sprite_delay_line #(
    .WIDTH (18),
    .DEPTH (LATENCY - 1)
  ) u_stage1 (
    .clk    (clk),
    .rst    (rst),
    .din_i  ({inside_s, de, bg_pixel}),
    .dout_o ({inside_d1, de_d1, bg_d1})
  );

  always_comb begin
    spr_hit_d = inside_d1 && is_opaque(rom_data, KEY_COLOR);
    pix_out_d = 16'h0000;
    if (!de_d1) begin
      pix_out_d = 16'h0000;
    end else if (spr_hit_d) begin
      pix_out_d = rom_data;
    end else begin
      pix_out_d = bg_d1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out_q <= 16'h0000;
      pix_de_q  <= 1'b0;
      spr_hit_q <= 1'b0;
    end else begin
      pix_out_q <= pix_out_d;
      pix_de_q  <= de_d1;
      spr_hit_q <= spr_hit_d && de_d1;
    end
  end

  assign pix_out = pix_out_q;
  assign pix_de  = pix_de_q;
  assign spr_hit = spr_hit_q;

endmodule

// File: tb/tb_sprite_overlay_fetch.sv
// Bench for sprite_overlay_fetch: geometric reference model, ROM model returning
// data=addr (one key texel), scoreboard queue for the two-cycle output latency.
module tb_sprite_overlay_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, de, spr_en;
  logic [9:0]  pix_x, pix_y, spr_x, spr_y;
  logic [15:0] bg_pixel;
  logic [12:0] rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic [15:0] pix_out;
  logic        pix_de, spr_hit;

  always #5 clk = ~clk;

  sprite_overlay_fetch dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .de(de),
    .pix_x(pix_x), .pix_y(pix_y), .bg_pixel(bg_pixel),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_out(pix_out), .pix_de(pix_de), .spr_hit(spr_hit)
  );

  typedef struct {
    int en, sx, sy, y0, y1, x0, x1, chg_row, chg_x;
  } frame_t;

  typedef struct {
    int          frame, px, py;
    logic [15:0] bg;
    int          exp_addr;
    logic [15:0] exp_out;
    logic        exp_de, exp_hit;
  } vec_t;

  typedef struct {
    int          due;
    string       name;
    logic [15:0] out;
    logic        de_v, hit;
  } exp_t;

  localparam int NF = 7;
  localparam int NV = 12;
  frame_t frames [NF];
  vec_t   vecs [NV];
  exp_t   sb [$];

  int checks = 0, passes = 0, cyc = 0;
  int key_addr = 920;
  int m_active = 0, m_en = 0, m_sx = 0, m_sy = 0, m_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] rom_fn(input int a);
    if (a == key_addr) return 16'hF81F;
    else return 16'(a);
  endfunction

  function automatic logic [15:0] bg_fn(input int x, input int y);
    return 16'(x * 37 + y * 1001 + 5);
  endfunction

  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due == cyc) begin
        check({e.name, ".pix_out"}, pix_out, e.out);
        check({e.name, ".pix_de"},  pix_de,  e.de_v);
        check({e.name, ".spr_hit"}, spr_hit, e.hit);
      end
    end
  end

  task automatic drive(input bit fs, input bit d, input int x, input int y,
                       input logic [15:0] bg, input int pidx);
    bit          ins, hit;
    int          a;
    logic [15:0] tex, out;
    exp_t        e;
    @(posedge clk); #1;
    frame_start = fs; de = d; pix_x = 10'(x); pix_y = 10'(y); bg_pixel = bg;
    ins = !fs && (m_active != 0) && (m_en != 0) && d &&
          y >= m_sy && y < m_sy + 90 && x >= m_sx && x < m_sx + 90;
    if (ins) m_last = (y - m_sy) * 90 + (x - m_sx);
    a = m_last;
    if (fs) begin
      m_active = 1; m_en = int'(spr_en); m_sx = int'(spr_x); m_sy = int'(spr_y);
    end
    tex = rom_fn(a);
    hit = ins && (tex != 16'hF81F);
    out = !d ? 16'h0000 : (hit ? tex : bg);
    #1;
    check("rom_addr", rom_addr, a);
    e.due = cyc + 2; e.name = "model"; e.out = out; e.de_v = d; e.hit = hit;
    sb.push_back(e);
    if (pidx >= 0) begin
      if (vecs[pidx].exp_addr >= 0) check($sformatf("probe%0d.rom_addr", pidx), rom_addr, vecs[pidx].exp_addr);
      e.name = $sformatf("probe%0d", pidx);
      e.out = vecs[pidx].exp_out; e.de_v = vecs[pidx].exp_de; e.hit = vecs[pidx].exp_hit;
      sb.push_back(e);
    end
  endtask

  task automatic run_frame(input int fi);
    frame_t f;
    int     pidx;
    f = frames[fi];
    spr_en = (f.en != 0); spr_x = 10'(f.sx); spr_y = 10'(f.sy);
    for (int y = f.y0; y <= f.y1; y++) begin
      if (y == f.chg_row) spr_x = 10'(f.chg_x);
      for (int x = f.x0; x <= f.x1; x++) begin
        pidx = -1;
        for (int k = 0; k < NV; k++)
          if (vecs[k].frame == fi && vecs[k].px == x && vecs[k].py == y) pidx = k;
        drive(y == f.y0 && x == f.x0, x < 640 && y < 480, x, y,
              (pidx >= 0) ? vecs[pidx].bg : bg_fn(x, y), pidx);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // en, sx, sy, y0, y1, x0, x1, chg_row, chg_x
    frames[0] = '{1, 100,  50,  48, 141,  98, 191, -1,   0};
    frames[1] = '{1, 600,  10,   9, 101, 596, 643, -1,   0};
    frames[2] = '{0, 100,  50,  48,  60,  98, 110, -1,   0};
    frames[3] = '{1, 700, 500,  48,  55,  98, 105, -1,   0};
    frames[4] = '{1, 100,  20,  19,  22,  98, 110, 20, 300};
    frames[5] = '{1, 300,  20,  19,  21, 297, 303, -1,   0};
    frames[6] = '{1, 100,  50,  49,  51,  98, 102, -1,   0};
    // frame, px, py, bg, exp_addr, exp_out, exp_de, exp_hit
    vecs[0]  = '{0, 100,  50, 16'hABCD,    0, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{0, 189, 139, 16'h1111, 8099, 16'h1FA3, 1'b1, 1'b1};
    vecs[2]  = '{0, 120,  60, 16'h07E0,  920, 16'h07E0, 1'b1, 1'b0};
    vecs[3]  = '{1, 600,  11, 16'h2222,   90, 16'h005A, 1'b1, 1'b1};
    vecs[4]  = '{1, 600,  99, 16'h3333, 8010, 16'h1F4A, 1'b1, 1'b1};
    vecs[5]  = '{1, 640,  10, 16'h4444,   39, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{2, 100,  50, 16'h5555,   -1, 16'h5555, 1'b1, 1'b0};
    vecs[7]  = '{3, 100,  50, 16'h6666,   -1, 16'h6666, 1'b1, 1'b0};
    vecs[8]  = '{4, 100,  21, 16'h7777,   90, 16'h005A, 1'b1, 1'b1};
    vecs[9]  = '{5, 300,  20, 16'h8888,    0, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{5, 299,  20, 16'h9999,   -1, 16'h9999, 1'b1, 1'b0};
    vecs[11] = '{6, 100,  51, 16'hAAAA,   90, 16'h005A, 1'b1, 1'b1};

    rst = 1'b1; frame_start = 1'b0; de = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
    bg_pixel = 16'h0000; spr_en = 1'b0; spr_x = 10'd0; spr_y = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.pix_out", pix_out, 16'h0000);
    check("reset.pix_de", pix_de, 1'b0);
    check("reset.spr_hit", spr_hit, 1'b0);
    check("reset.rom_addr", rom_addr, 13'd0);
    @(negedge clk) rst = 1'b0;

    // Background before any frame_start, then all table frames in order.
    for (int x = 10; x < 20; x++) drive(1'b0, 1'b1, x, 5, bg_fn(x, 5), -1);
    for (int fi = 0; fi < NF - 1; fi++) run_frame(fi);

    // Asynchronous reset while drawing, then background until the next frame.
    spr_en = 1'b1; spr_x = 10'd100; spr_y = 10'd50;
    for (int y = 49; y <= 50; y++)
      for (int x = 98; x <= 110; x++)
        drive(y == 49 && x == 98, 1'b1, x, y, bg_fn(x, y), -1);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("async_rst.pix_out", pix_out, 16'h0000);
    check("async_rst.pix_de", pix_de, 1'b0);
    check("async_rst.spr_hit", spr_hit, 1'b0);
    check("async_rst.rom_addr", rom_addr, 13'd0);
    sb.delete();
    m_active = 0; m_last = 0;
    #1 rst = 1'b0;
    for (int y = 50; y <= 52; y++)
      for (int x = 98; x <= 110; x++)
        drive(1'b0, 1'b1, x, y, bg_fn(x, y), -1);
    run_frame(6);

    drive(1'b0, 1'b0, 0, 0, 16'h0000, -1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
